// File: rtl/z80_bus_responder.sv
// Slave-side Z80 bus responder: internal byte RAM, programmable wait states,
// I/O strobe forwarding and interrupt-acknowledge vector return.
module z80_bus_responder #(
    parameter int unsigned DEPTH      = 16384,
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned M1_WAIT    = 0,
    parameter int unsigned IO_WAIT    = 1,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        M1_L,
    output logic        WAIT_L,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_rd_en,
    output logic        io_wr_en,
    input  logic [7:0]  io_rdata,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_MEM  = 2'd0,
        K_IO   = 2'd1,
        K_INTA = 2'd2
    } kind_t;

    logic [7:0] mem [DEPTH];

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          wait_l_q, wait_l_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    io_addr_q, io_addr_d;
    logic [7:0]    io_wdata_q, io_wdata_d;
    logic          io_rd_en_q, io_rd_en_d;
    logic          io_wr_en_q, io_wr_en_d;
    logic          pend_q, pend_d;

    logic          strobes_idle;
    logic          any_dir;
    logic          req_mem, req_io, req_inta, req_any;
    kind_t         req_kind;
    logic          req_rd;
    logic [4:0]    n_wait;
    logic          do_access;
    kind_t         acc_kind;
    logic          acc_rd;
    logic [AW-1:0] acc_addr;
    logic          mem_we;
    logic          addr_unused;

    // Upper address bits beyond the RAM size are mirrored away by design.
    assign addr_unused = ^addr_bus;

    // Request decode: memory beats int-ack beats plain I/O; read beats write.
    always_comb begin
        strobes_idle = MREQ_L & IORQ_L & RD_L & WR_L;
        any_dir      = ~RD_L | ~WR_L;
        req_mem      = ~MREQ_L & any_dir;
        req_inta     = ~req_mem & ~IORQ_L & ~M1_L;
        req_io       = ~req_mem & ~req_inta & ~IORQ_L & any_dir;
        req_any      = req_mem | req_io | req_inta;
        req_kind     = K_MEM;
        req_rd       = ~RD_L;
        n_wait       = 5'd0;
        if (req_mem) begin
            req_kind = K_MEM;
            n_wait   = 5'(MEM_WAIT) + (M1_L ? 5'd0 : 5'(M1_WAIT));
        end else if (req_inta) begin
            req_kind = K_INTA;
            req_rd   = 1'b1;
        end else if (req_io) begin
            req_kind = K_IO;
            n_wait   = 5'(IO_WAIT);
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wait_l_d    = wait_l_q;
        cpu_rdata_d = cpu_rdata_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        io_rd_en_d  = 1'b0;
        io_wr_en_d  = 1'b0;
        pend_d      = pend_q;
        do_access   = 1'b0;
        acc_kind    = kind_q;
        acc_rd      = rd_q;
        acc_addr    = addr_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    kind_d   = req_kind;
                    rd_d     = req_rd;
                    addr_d   = addr_bus[AW-1:0];
                    acc_kind = req_kind;
                    acc_rd   = req_rd;
                    acc_addr = addr_bus[AW-1:0];
                    if (req_io) begin
                        io_addr_d = addr_bus[7:0];
                    end
                    if (n_wait != 5'd0) begin
                        cnt_d    = n_wait - 5'd1;
                        wait_l_d = 1'b0;
                        state_d  = ST_WAIT;
                    end else begin
                        cnt_d     = 5'd0;
                        do_access = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                // A full strobe release mid-wait abandons the cycle with no side effects.
                if (strobes_idle) begin
                    state_d  = ST_IDLE;
                    wait_l_d = 1'b1;
                    cnt_d    = 5'd0;
                end else if (cnt_q == 5'd0) begin
                    do_access = 1'b1;
                    wait_l_d  = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DONE: begin
                if (pend_q) begin
                    cpu_rdata_d = io_rdata;
                    pend_d      = 1'b0;
                end else if (strobes_idle) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access) begin
            case (acc_kind)
                K_MEM: begin
                    if (acc_rd) begin
                        cpu_rdata_d = mem[acc_addr];
                    end else begin
                        mem_we = 1'b1;
                    end
                end
                K_IO: begin
                    if (acc_rd) begin
                        io_rd_en_d = 1'b1;
                        pend_d     = 1'b1;
                    end else begin
                        io_wr_en_d = 1'b1;
                        io_wdata_d = cpu_wdata;
                    end
                end
                K_INTA: begin
                    cpu_rdata_d = INT_VECTOR;
                end
                default: begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            kind_q      <= K_MEM;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= 5'd0;
            wait_l_q    <= 1'b1;
            cpu_rdata_q <= 8'h00;
            io_addr_q   <= 8'h00;
            io_wdata_q  <= 8'h00;
            io_rd_en_q  <= 1'b0;
            io_wr_en_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wait_l_q    <= wait_l_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            io_rd_en_q  <= io_rd_en_d;
            io_wr_en_q  <= io_wr_en_d;
            pend_q      <= pend_d;
        end
    end

    // RAM is never cleared; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_L) begin
            mem[acc_addr] <= cpu_wdata;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign WAIT_L    = wait_l_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;
    assign io_rd_en  = io_rd_en_q;
    assign io_wr_en  = io_wr_en_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: memory, M1 fetch, mirroring, I/O,
// interrupt acknowledge, priority, abort and mid-cycle reset.
`timescale 1ns/1ps
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic [15:0] addr_bus = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        MREQ_L = 1'b1;
    logic        IORQ_L = 1'b1;
    logic        RD_L = 1'b1;
    logic        WR_L = 1'b1;
    logic        M1_L = 1'b1;
    logic        WAIT_L;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [7:0]  io_rdata = 8'h00;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int rd_pulse_total = 0;
    int wr_pulse_total = 0;

    z80_bus_responder #(
        .DEPTH(16384), .MEM_WAIT(1), .M1_WAIT(1), .IO_WAIT(1), .INT_VECTOR(8'hFF)
    ) dut (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L),
        .WR_L(WR_L), .M1_L(M1_L), .WAIT_L(WAIT_L), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en),
        .io_rdata(io_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io_rd_en) rd_pulse_total++;
        if (io_wr_en) wr_pulse_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic mreq, input logic iorq, input logic rd,
                             input logic wr, input logic m1,
                             input logic [15:0] a, input logic [7:0] d);
        MREQ_L = mreq; IORQ_L = iorq; RD_L = rd; WR_L = wr; M1_L = m1;
        addr_bus = a; cpu_wdata = d;
    endtask

    task automatic release_bus();
        MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
        tick();
    endtask

    // Advances to the edge where WAIT_L is high again; lows = cycles seen low.
    task automatic wait_access(output int lows);
        lows = 0;
        tick();
        while (WAIT_L === 1'b0 && lows < 40) begin
            lows++;
            tick();
        end
        checks++;
        if (lows >= 40) begin
            errors++;
            $display("FAIL wait_timeout got %0d low cycles exp < 40", lows);
        end
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d, output int lows);
        drive_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, d);
        wait_access(lows);
        release_bus();
    endtask

    task automatic mem_read(input logic [15:0] a, input logic m1,
                            output int lows, output logic [7:0] data);
        drive_req(1'b0, 1'b1, 1'b0, 1'b1, m1, a, 8'h00);
        wait_access(lows);
        data = cpu_rdata;
        release_bus();
    endtask

    task automatic test_reset();
        tick();
        checks++; if (WAIT_L !== 1'b1) begin errors++; $display("FAIL reset_wait_l got %b exp 1", WAIT_L); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
        checks++; if (io_rd_en !== 1'b0 || io_wr_en !== 1'b0) begin errors++; $display("FAIL reset_io_en got %b%b exp 00", io_rd_en, io_wr_en); end
        checks++; if (io_addr !== 8'h00 || io_wdata !== 8'h00) begin errors++; $display("FAIL reset_io_bus got %h/%h exp 00/00", io_addr, io_wdata); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        rst_L = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd0 || WAIT_L !== 1'b1) begin errors++; $display("FAIL post_reset_idle got st=%0d wait=%b exp st=0 wait=1", dbg_state, WAIT_L); end
    endtask

    task automatic test_mem_write_read();
        int lows;
        logic [7:0] data;
        mem_write(16'h0123, 8'hA5, lows);
        checks++; if (lows !== 1) begin errors++; $display("FAIL memwr_wait got %0d exp 1", lows); end
        mem_read(16'h0123, 1'b1, lows, data);
        checks++; if (lows !== 1) begin errors++; $display("FAIL memrd_wait got %0d exp 1", lows); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL memrd_data got %h exp a5", data); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL memrd_idle got %0d exp 0", dbg_state); end
    endtask

    task automatic test_m1_fetch();
        int lows;
        logic [7:0] data;
        mem_write(16'h0200, 8'h3B, lows);
        mem_read(16'h0200, 1'b0, lows, data);
        checks++; if (lows !== 2) begin errors++; $display("FAIL m1_wait got %0d exp 2", lows); end
        checks++; if (data !== 8'h3B) begin errors++; $display("FAIL m1_data got %h exp 3b", data); end
    endtask

    task automatic test_mirror();
        int lows;
        logic [7:0] data;
        mem_write(16'h4010, 8'h3C, lows);
        mem_read(16'h0010, 1'b1, lows, data);
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL mirror_0010 got %h exp 3c", data); end
        mem_read(16'hC010, 1'b1, lows, data);
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL mirror_c010 got %h exp 3c", data); end
    endtask

    task automatic test_io();
        int lows;
        int r0;
        int w0;
        logic [7:0] data;
        r0 = rd_pulse_total; w0 = wr_pulse_total;
        drive_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h127E, 8'h55);
        wait_access(lows);
        release_bus();
        checks++; if (lows !== 1) begin errors++; $display("FAIL iowr_wait got %0d exp 1", lows); end
        checks++; if (wr_pulse_total - w0 !== 1) begin errors++; $display("FAIL iowr_pulses got %0d exp 1", wr_pulse_total - w0); end
        checks++; if (rd_pulse_total - r0 !== 0) begin errors++; $display("FAIL iowr_rd_pulses got %0d exp 0", rd_pulse_total - r0); end
        checks++; if (io_addr !== 8'h7E || io_wdata !== 8'h55) begin errors++; $display("FAIL iowr_bus got %h/%h exp 7e/55", io_addr, io_wdata); end
        r0 = rd_pulse_total; w0 = wr_pulse_total;
        io_rdata = 8'h9A;
        drive_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0033, 8'h00);
        wait_access(lows);
        tick();
        data = cpu_rdata;
        release_bus();
        io_rdata = 8'h00;
        checks++; if (lows !== 1) begin errors++; $display("FAIL iord_wait got %0d exp 1", lows); end
        checks++; if (data !== 8'h9A) begin errors++; $display("FAIL iord_data got %h exp 9a", data); end
        checks++; if (rd_pulse_total - r0 !== 1) begin errors++; $display("FAIL iord_pulses got %0d exp 1", rd_pulse_total - r0); end
        checks++; if (wr_pulse_total - w0 !== 0) begin errors++; $display("FAIL iord_wr_pulses got %0d exp 0", wr_pulse_total - w0); end
        checks++; if (io_addr !== 8'h33) begin errors++; $display("FAIL iord_addr got %h exp 33", io_addr); end
    endtask

    task automatic test_inta();
        int lows;
        int r0;
        int w0;
        logic [7:0] data;
        r0 = rd_pulse_total; w0 = wr_pulse_total;
        drive_req(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        wait_access(lows);
        data = cpu_rdata;
        release_bus();
        checks++; if (lows !== 0) begin errors++; $display("FAIL inta_wait got %0d exp 0", lows); end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL inta_vector got %h exp ff", data); end
        checks++; if (rd_pulse_total - r0 !== 0 || wr_pulse_total - w0 !== 0) begin errors++; $display("FAIL inta_io_pulses got rd=%0d wr=%0d exp 0/0", rd_pulse_total - r0, wr_pulse_total - w0); end
    endtask

    task automatic test_priority();
        int lows;
        int w0;
        logic [7:0] data;
        mem_write(16'h0050, 8'h11, lows);
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0050, 8'hEE);
        wait_access(lows);
        data = cpu_rdata;
        release_bus();
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL prio_rdwr_data got %h exp 11", data); end
        mem_read(16'h0050, 1'b1, lows, data);
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL prio_rdwr_nowrite got %h exp 11", data); end
        w0 = wr_pulse_total;
        drive_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0060, 8'h77);
        wait_access(lows);
        release_bus();
        checks++; if (wr_pulse_total - w0 !== 0) begin errors++; $display("FAIL prio_mreq_io_pulse got %0d exp 0", wr_pulse_total - w0); end
        mem_read(16'h0060, 1'b1, lows, data);
        checks++; if (data !== 8'h77) begin errors++; $display("FAIL prio_mreq_mem got %h exp 77", data); end
    endtask

    task automatic test_abort();
        int lows;
        logic [7:0] data;
        mem_write(16'h0300, 8'h5A, lows);
        drive_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 8'h99);
        tick();
        checks++; if (WAIT_L !== 1'b0) begin errors++; $display("FAIL abort_wait_low got %b exp 0", WAIT_L); end
        release_bus();
        checks++; if (WAIT_L !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL abort_idle got wait=%b st=%0d exp wait=1 st=0", WAIT_L, dbg_state); end
        mem_read(16'h0300, 1'b1, lows, data);
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL abort_nowrite got %h exp 5a", data); end
        drive_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 8'hAB);
        tick();
        checks++; if (WAIT_L !== 1'b0) begin errors++; $display("FAIL rstmid_wait_low got %b exp 0", WAIT_L); end
        #1 rst_L = 1'b0;
        #1;
        checks++; if (WAIT_L !== 1'b1 || cpu_rdata !== 8'h00 || dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got wait=%b rdata=%h st=%0d exp 1/00/0", WAIT_L, cpu_rdata, dbg_state); end
        MREQ_L = 1'b1; WR_L = 1'b1;
        #1 rst_L = 1'b1;
        tick();
        mem_read(16'h0300, 1'b1, lows, data);
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL rstmid_nowrite got %h exp 5a", data); end
    endtask

    task automatic test_back_to_back();
        int lows;
        logic [7:0] d0;
        logic [7:0] d1;
        mem_read(16'h0123, 1'b1, lows, d0);
        mem_read(16'h4010, 1'b1, lows, d1);
        checks++; if (d0 !== 8'hA5 || d1 !== 8'h3C) begin errors++; $display("FAIL b2b_data got %h/%h exp a5/3c", d0, d1); end
        checks++; if (lows !== 1) begin errors++; $display("FAIL b2b_wait got %0d exp 1", lows); end
    endtask

    initial begin
        test_reset();
        test_mem_write_read();
        test_m1_fetch();
        test_mirror();
        test_io();
        test_inta();
        test_priority();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
